// File: rtl/adc_conversion_sequencer.sv
// Line-readout sequencer for a linear image sensor front-end.
// Runs a free-running pixel timebase (dummy preamble, then active pixels) and
// issues one ADC start-of-conversion pulse per channel per active pixel,
// dropping a pulse and flagging overrun when the ADC reports busy.
module adc_conversion_sequencer #(
  parameter int CICLOS_FORMAS_DE_ONDA = 8,
  parameter int PIXELES               = 2048,
  parameter int PIXELES_DUMMY         = 5,
  parameter int N_CANALES             = 1,
  parameter int ANCHO_PULSO           = 1
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_enable,
  input  logic        i_start_line,
  input  logic        i_adc_busy,
  output logic        o_adc_start_conversion,
  output logic [2:0]  o_channel,
  output logic [15:0] o_pixel_index,
  output logic        o_line_active,
  output logic        o_line_done,
  output logic        o_overrun
);

  localparam int PHASE_W = (CICLOS_FORMAS_DE_ONDA > 2) ? $clog2(CICLOS_FORMAS_DE_ONDA) : 1;
  localparam int PW_W    = (ANCHO_PULSO > 1) ? $clog2(ANCHO_PULSO + 1) : 1;

  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(CICLOS_FORMAS_DE_ONDA - 1);
  localparam logic [15:0]        PIX_LAST   = 16'(PIXELES - 1);
  localparam logic [23:0]        DUMMY_LAST = 24'(PIXELES_DUMMY * CICLOS_FORMAS_DE_ONDA - 1);
  localparam logic [PW_W-1:0]    PULSE_LAST = PW_W'(ANCHO_PULSO - 1);

  // Every channel slot (2*ANCHO_PULSO wide) must fit inside one pixel period.
  if (CICLOS_FORMAS_DE_ONDA < 2 * ANCHO_PULSO * N_CANALES) begin : g_cfg_check
    $fatal(1, "adc_conversion_sequencer: CICLOS_FORMAS_DE_ONDA must be >= 2*ANCHO_PULSO*N_CANALES");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_DUMMY,
    S_PIXEL,
    S_DONE
  } state_t;

  state_t             state;
  logic [PHASE_W-1:0] phase_cnt;
  logic [23:0]        dummy_cnt;
  logic [PW_W-1:0]    pulse_cnt;
  logic               rise_req;
  logic [2:0]         rise_ch;

  // Decide whether a start pulse is due to rise on the coming edge, i.e. the
  // phase after this edge lands on a channel slot inside the active region.
  always_comb begin
    rise_req = 1'b0;
    rise_ch  = 3'd0;
    case (state)
      S_IDLE:  rise_req = i_start_line && (PIXELES_DUMMY == 0);
      S_DUMMY: rise_req = (dummy_cnt == DUMMY_LAST);
      S_PIXEL: begin
        if (phase_cnt == PHASE_LAST) begin
          rise_req = (o_pixel_index != PIX_LAST);
        end else begin
          for (int k = 1; k < N_CANALES; k++) begin
            if (phase_cnt == PHASE_W'(k * 2 * ANCHO_PULSO - 1)) begin
              rise_req = 1'b1;
              rise_ch  = 3'(k);
            end
          end
        end
      end
      default: rise_req = 1'b0;
    endcase
  end

  // Sequencer FSM, timebase counters and registered outputs.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state                  <= S_IDLE;
      phase_cnt              <= '0;
      dummy_cnt              <= '0;
      pulse_cnt              <= '0;
      o_adc_start_conversion <= 1'b0;
      o_channel              <= 3'd0;
      o_pixel_index          <= 16'd0;
      o_line_active          <= 1'b0;
      o_line_done            <= 1'b0;
      o_overrun              <= 1'b0;
    end else if (!i_enable) begin
      // Abort: back to idle with everything cleared; overrun is kept for inspection.
      state                  <= S_IDLE;
      phase_cnt              <= '0;
      dummy_cnt              <= '0;
      pulse_cnt              <= '0;
      o_adc_start_conversion <= 1'b0;
      o_channel              <= 3'd0;
      o_pixel_index          <= 16'd0;
      o_line_active          <= 1'b0;
      o_line_done            <= 1'b0;
    end else begin
      o_line_done <= 1'b0;

      case (state)
        S_IDLE: begin
          phase_cnt     <= '0;
          dummy_cnt     <= '0;
          o_pixel_index <= 16'd0;
          if (i_start_line) begin
            o_overrun     <= 1'b0;
            o_line_active <= 1'b1;
            state         <= (PIXELES_DUMMY == 0) ? S_PIXEL : S_DUMMY;
          end
        end
        S_DUMMY: begin
          if (dummy_cnt == DUMMY_LAST) begin
            state         <= S_PIXEL;
            dummy_cnt     <= '0;
            phase_cnt     <= '0;
            o_pixel_index <= 16'd0;
          end else begin
            dummy_cnt <= dummy_cnt + 1'b1;
          end
        end
        S_PIXEL: begin
          if (phase_cnt == PHASE_LAST) begin
            phase_cnt <= '0;
            if (o_pixel_index == PIX_LAST) begin
              state         <= S_DONE;
              o_pixel_index <= 16'd0;
              o_line_active <= 1'b0;
              o_line_done   <= 1'b1;
            end else begin
              o_pixel_index <= o_pixel_index + 1'b1;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase

      if (o_adc_start_conversion) begin
        if (pulse_cnt == '0) begin
          o_adc_start_conversion <= 1'b0;
        end else begin
          pulse_cnt <= pulse_cnt - 1'b1;
        end
      end

      // A suppressed pulse leaves o_channel on the last pulse actually issued.
      // Placed last so a drop on the very first slot still sets overrun.
      if (rise_req) begin
        if (i_adc_busy) begin
          o_overrun <= 1'b1;
        end else begin
          o_adc_start_conversion <= 1'b1;
          pulse_cnt              <= PULSE_LAST;
          o_channel              <= rise_ch;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_conversion_sequencer.sv
// Testbench for adc_conversion_sequencer: small-line configuration checked every
// cycle against an offset-arithmetic reference model, plus a legacy-size instance.
module tb_adc_conversion_sequencer;

  localparam int C  = 8;
  localparam int P  = 4;
  localparam int PD = 2;
  localparam int N  = 2;
  localparam int W  = 2;
  localparam int L  = (PD + P) * C;
  localparam int DC = PD * C;

  logic        clk;
  logic        rst_n, en, st, bz;
  logic        pulse, act, done, ovr;
  logic [2:0]  ch;
  logic [15:0] pix;

  logic        leg_en, leg_st, leg_bz;
  logic        leg_pulse, leg_act, leg_done, leg_ovr;
  logic [2:0]  leg_ch;
  logic [15:0] leg_pix;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  adc_conversion_sequencer #(
    .CICLOS_FORMAS_DE_ONDA(C), .PIXELES(P), .PIXELES_DUMMY(PD),
    .N_CANALES(N), .ANCHO_PULSO(W)
  ) u_dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(en), .i_start_line(st),
    .i_adc_busy(bz), .o_adc_start_conversion(pulse), .o_channel(ch),
    .o_pixel_index(pix), .o_line_active(act), .o_line_done(done), .o_overrun(ovr)
  );

  adc_conversion_sequencer #(
    .CICLOS_FORMAS_DE_ONDA(8), .PIXELES(2048), .PIXELES_DUMMY(5),
    .N_CANALES(1), .ANCHO_PULSO(1)
  ) u_leg (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(leg_en), .i_start_line(leg_st),
    .i_adc_busy(leg_bz), .o_adc_start_conversion(leg_pulse), .o_channel(leg_ch),
    .o_pixel_index(leg_pix), .o_line_active(leg_act), .o_line_done(leg_done),
    .o_overrun(leg_ovr)
  );

  // Reference model state: line start known as an edge offset, not a state machine.
  bit m_live;
  int m_u;
  int m_chan;
  bit m_ovr;
  bit dropped [P][N];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_live = 1'b0;
    m_u    = 0;
    m_chan = 0;
    m_ovr  = 1'b0;
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic model_edge(input bit s, input bit e, input bit b);
    int v, ph, k;
    if (!e) begin
      m_live = 1'b0;
      m_chan = 0;
    end else begin
      if (m_live) m_u++;
      if ((!m_live || m_u >= L + 2) && s) begin
        m_live = 1'b1;
        m_u    = 0;
        m_ovr  = 1'b0;
        for (int i = 0; i < P; i++)
          for (int j = 0; j < N; j++) dropped[i][j] = 1'b0;
      end
      if (m_live && m_u >= DC && m_u < L) begin
        v  = m_u - DC;
        ph = v % C;
        k  = ph / (2 * W);
        if ((ph % (2 * W)) == 0 && k < N) begin
          if (b) begin
            dropped[v / C][k] = 1'b1;
            m_ovr             = 1'b1;
          end else begin
            m_chan = k;
          end
        end
      end
    end
  endtask

  function automatic logic [22:0] model_out();
    logic        p_exp;
    logic [15:0] pix_exp;
    int v, ph, k;
    p_exp   = 1'b0;
    pix_exp = 16'd0;
    if (m_live && m_u >= DC && m_u < L) begin
      v       = m_u - DC;
      ph      = v % C;
      k       = ph / (2 * W);
      pix_exp = 16'(v / C);
      if (k < N && (ph % (2 * W)) < W) begin
        if (!dropped[v / C][k]) p_exp = 1'b1;
      end
    end
    return {p_exp, 3'(m_chan), pix_exp, (m_live && m_u < L), (m_live && m_u == L), m_ovr};
  endfunction

  function automatic logic [22:0] dut_vec();
    return {pulse, ch, pix, act, done, ovr};
  endfunction

  // One clock: drive inputs, let the edge happen, compare against the model.
  task automatic step(input bit s, input bit e, input bit b);
    st = s; en = e; bz = b;
    @(posedge clk);
    model_edge(s, e, b);
    #1;
    check($sformatf("cycle%0d", cyc), 32'(dut_vec()), 32'(model_out()));
    cyc++;
  endtask

  logic        cp_pulse [64];
  logic [2:0]  cp_ch    [64];
  logic [15:0] cp_pix   [64];
  logic        cp_act   [64];
  logic        cp_done  [64];
  logic        cp_ovr   [64];

  task automatic cap(input int t);
    cp_pulse[t] = pulse; cp_ch[t] = ch; cp_pix[t] = pix;
    cp_act[t]   = act;   cp_done[t] = done; cp_ovr[t] = ovr;
  endtask

  typedef struct {
    int          t;
    logic        pulse;
    logic [2:0]  ch;
    logic [15:0] pix;
    logic        act;
    logic        done;
    logic        ovr;
  } vec_t;

  vec_t tbl [18];

  initial begin
    int n_done, n_rise, first_t, last_t, done_t;
    logic prev;
    logic [15:0] max_pix;

    // Expected outputs after edge E0+t of a clean line.
    tbl[0]  = '{0,  1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{15, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{16, 1'b1, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{17, 1'b1, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{18, 1'b0, 3'd0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[5]  = '{20, 1'b1, 3'd1, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{22, 1'b0, 3'd1, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{24, 1'b1, 3'd0, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{28, 1'b1, 3'd1, 16'd1, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{32, 1'b1, 3'd0, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{36, 1'b1, 3'd1, 16'd2, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{40, 1'b1, 3'd0, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{44, 1'b1, 3'd1, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[13] = '{45, 1'b1, 3'd1, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{46, 1'b0, 3'd1, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[15] = '{47, 1'b0, 3'd1, 16'd3, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{48, 1'b0, 3'd1, 16'd0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{49, 1'b0, 3'd1, 16'd0, 1'b0, 1'b0, 1'b0};

    rst_n = 1'b0; en = 1'b1; st = 1'b0; bz = 1'b0;
    leg_en = 1'b1; leg_st = 1'b0; leg_bz = 1'b0;
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_pulse", 32'(pulse), 0);
    check("rst_ch", 32'(ch), 0);
    check("rst_pix", 32'(pix), 0);
    check("rst_act", 32'(act), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ovr", 32'(ovr), 0);
    rst_n = 1'b1;
    repeat (4) step(0, 1, 0);

    // Basic line, compared against the hand-derived table
    step(1, 1, 0); cap(0);
    for (int t = 1; t <= 49; t++) begin step(0, 1, 0); cap(t); end
    for (int i = 0; i < 18; i++) begin
      check($sformatf("basic_pulse_t%0d", tbl[i].t), 32'(cp_pulse[tbl[i].t]), 32'(tbl[i].pulse));
      check($sformatf("basic_ch_t%0d", tbl[i].t), 32'(cp_ch[tbl[i].t]), 32'(tbl[i].ch));
      check($sformatf("basic_pix_t%0d", tbl[i].t), 32'(cp_pix[tbl[i].t]), 32'(tbl[i].pix));
      check($sformatf("basic_act_t%0d", tbl[i].t), 32'(cp_act[tbl[i].t]), 32'(tbl[i].act));
      check($sformatf("basic_done_t%0d", tbl[i].t), 32'(cp_done[tbl[i].t]), 32'(tbl[i].done));
      check($sformatf("basic_ovr_t%0d", tbl[i].t), 32'(cp_ovr[tbl[i].t]), 32'(tbl[i].ovr));
    end
    repeat (2) step(0, 1, 0);

    // Busy at the pixel-2 channel-1 rise edge only
    step(1, 1, 0); cap(0);
    for (int t = 1; t <= 49; t++) begin step(0, 1, (t == 36)); cap(t); end
    check("drop_pulse36", 32'(cp_pulse[36]), 0);
    check("drop_pulse37", 32'(cp_pulse[37]), 0);
    check("drop_pulse32", 32'(cp_pulse[32]), 1);
    check("drop_pulse40", 32'(cp_pulse[40]), 1);
    check("drop_ovr35", 32'(cp_ovr[35]), 0);
    check("drop_ovr36", 32'(cp_ovr[36]), 1);
    check("drop_ovr49", 32'(cp_ovr[49]), 1);
    step(0, 1, 0);
    check("drop_ovr_idle", 32'(ovr), 1);
    step(1, 1, 0);
    check("drop_ovr_clear", 32'(ovr), 0);
    repeat (49) step(0, 1, 0);

    // Starts during the line and in the DONE cycle are ignored
    n_done = 0;
    step(1, 1, 0);
    for (int t = 1; t <= 50; t++) begin
      step((t == 10) || (t == 49) || (t == 50), 1, 0);
      if (t < 50 && done) n_done++;
    end
    check("ign_one_done", 32'(n_done), 1);
    check("ign_restart_act", 32'(act), 1);
    repeat (49) step(0, 1, 0);

    // Abort by enable
    step(1, 1, 0);
    for (int t = 1; t <= 30; t++) step(0, 1, 0);
    step(0, 0, 0);
    check("abort_act", 32'(act), 0);
    check("abort_pix", 32'(pix), 0);
    check("abort_pulse", 32'(pulse), 0);
    n_done = 0; n_rise = 0;
    for (int t = 0; t < 20; t++) begin
      step(0, (t >= 5), 0);
      if (done) n_done++;
      if (pulse) n_rise++;
    end
    check("abort_no_done", 32'(n_done), 0);
    check("abort_no_pulse", 32'(n_rise), 0);
    n_done = 0; n_rise = 0; prev = 1'b0;
    step(1, 1, 0);
    for (int t = 1; t <= 49; t++) begin
      step(0, 1, 0);
      if (pulse && !prev) n_rise++;
      prev = pulse;
      if (done) n_done++;
    end
    check("reline_pulses", 32'(n_rise), 8);
    check("reline_done", 32'(n_done), 1);

    // Asynchronous reset in the middle of a pulse
    step(1, 1, 0);
    for (int t = 1; t <= 17; t++) step(0, 1, 0);
    check("pre_reset_pulse", 32'(pulse), 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outputs", 32'(dut_vec()), 0);
    model_reset();
    #2 rst_n = 1'b1;
    repeat (10) step(0, 1, 0);
    step(1, 1, 0);
    repeat (50) step(0, 1, 0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 29) == 0), ($urandom_range(0, 149) != 0), ($urandom_range(0, 3) == 0));
    en = 1'b1; st = 1'b0; bz = 1'b0;

    // Legacy-size configuration
    leg_st = 1'b1;
    @(posedge clk);
    #1;
    leg_st = 1'b0;
    n_rise = 0; first_t = -1; last_t = -1; done_t = -1; max_pix = 16'd0;
    prev = leg_pulse;
    for (int t = 1; t <= 16500; t++) begin
      @(posedge clk);
      #1;
      if (leg_pulse && !prev) begin
        n_rise++;
        if (first_t < 0) first_t = t;
        last_t = t;
      end
      prev = leg_pulse;
      if (leg_pix > max_pix) max_pix = leg_pix;
      if (leg_done && done_t < 0) done_t = t;
    end
    check("leg_pulses", 32'(n_rise), 2048);
    check("leg_first", 32'(first_t), 40);
    check("leg_last", 32'(last_t), 16416);
    check("leg_max_pix", 32'(max_pix), 2047);
    check("leg_done", 32'(done_t), 16424);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
